// File: rtl/hazard_controller.sv
// hazard_controller
// Central stall/flush sequencer for the 5-stage pipeline. It takes hazard and
// status inputs from decode, execute and memory. It drives every
// pipeline-register enable, bubble and flush. It also keeps two saturating
// performance counters.
//
// State table:
//   RUN       | normal issue; events are resolved by priority each cycle
//   MC_WAIT   | multi-cycle op in flight; stall until mc_done
//   MEM_WAIT  | data memory not ready; hold EX/MEM, bubble MEM/WB
//   BR_STALL2 | second bubble for a branch that depends on a load
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_rs1/2   ID-stage sources and their use flags
//   id_is_branch, PCSrc            ID branch and taken-branch resolution
//   id_ex_MemRead/RegWrite/rd      EX-stage instruction info
//   mc_start, mc_done              multi-cycle unit handshake
//   dmem_req, dmem_ready           data-memory handshake
//   PCWrite .. mc_go               combinational pipeline controls
//   mem_error                      sticky memory-timeout flag
//   stall_cycles, flush_count      saturating performance counters
module hazard_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_is_branch,
  input  logic             PCSrc,
  input  logic             id_ex_MemRead,
  input  logic             id_ex_RegWrite,
  input  logic [4:0]       id_ex_rd,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             FetchWrite,
  output logic             MakeBubble,
  output logic             IF_Flush,
  output logic             ex_hold,
  output logic             mem_bubble,
  output logic             wb_bubble,
  output logic             mem_hold,
  output logic             mc_go,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] MC_WAIT   = 2'd1;
  localparam logic [1:0] MEM_WAIT  = 2'd2;
  localparam logic [1:0] BR_STALL2 = 2'd3;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             mc_go_pend, mc_go_pend_nxt;
  logic             mc_done_lat, mc_done_lat_nxt;
  logic             err_q, set_err;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             mem_stall, rs_match, load_use, br_haz;

  assign mem_stall = dmem_req && !dmem_ready;
  assign rs_match  = (id_ex_rd != 5'd0) &&
                     ((id_uses_rs1 && id_rs1 == id_ex_rd) ||
                      (id_uses_rs2 && id_rs2 == id_ex_rd));
  assign load_use  = id_ex_MemRead && rs_match;
  assign br_haz    = id_is_branch && id_ex_RegWrite && !id_ex_MemRead && rs_match;

  always_comb begin
    PCWrite         = 1'b1;
    FetchWrite      = 1'b1;
    MakeBubble      = 1'b0;
    IF_Flush        = 1'b0;
    ex_hold         = 1'b0;
    mem_bubble      = 1'b0;
    wb_bubble       = 1'b0;
    mem_hold        = 1'b0;
    mc_go           = 1'b0;
    set_err         = 1'b0;
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    mc_go_pend_nxt  = mc_go_pend;
    mc_done_lat_nxt = mc_done_lat;

    case (state)
      RUN: begin
        if (mem_stall) begin
          PCWrite      = 1'b0;
          FetchWrite   = 1'b0;
          ex_hold      = 1'b1;
          mem_hold     = 1'b1;
          wb_bubble    = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else if (mc_start) begin
          PCWrite    = 1'b0;
          FetchWrite = 1'b0;
          ex_hold    = 1'b1;
          mem_bubble = 1'b1;
          // Guard so one op can never launch the unit twice.
          if (!mc_go_pend) begin
            mc_go          = 1'b1;
            mc_go_pend_nxt = 1'b1;
          end
          state_nxt = MC_WAIT;
        end else if (load_use || br_haz) begin
          PCWrite    = 1'b0;
          FetchWrite = 1'b0;
          MakeBubble = 1'b1;
          // Branches resolve in ID, so a load feeding one needs a second bubble.
          if (load_use && id_is_branch) state_nxt = BR_STALL2;
        end else if (PCSrc) begin
          IF_Flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          // Abort: release the pipeline and flag the failure.
          set_err      = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          PCWrite      = 1'b0;
          FetchWrite   = 1'b0;
          ex_hold      = 1'b1;
          mem_hold     = 1'b1;
          wb_bubble    = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      MC_WAIT: begin
        PCWrite    = 1'b0;
        FetchWrite = 1'b0;
        ex_hold    = 1'b1;
        mem_bubble = 1'b1;
        if (mem_stall) begin
          // Memory stall overlaps the op; remember an early completion.
          mem_hold  = 1'b1;
          wb_bubble = 1'b1;
          if (mc_done) mc_done_lat_nxt = 1'b1;
        end else if (mc_done || mc_done_lat) begin
          PCWrite         = 1'b1;
          FetchWrite      = 1'b1;
          ex_hold         = 1'b0;
          mem_bubble      = 1'b0;
          state_nxt       = RUN;
          mc_done_lat_nxt = 1'b0;
          mc_go_pend_nxt  = 1'b0;
        end
      end

      BR_STALL2: begin
        PCWrite    = 1'b0;
        FetchWrite = 1'b0;
        MakeBubble = 1'b1;
        state_nxt  = RUN;
      end

      default: state_nxt = RUN;
    endcase

    if (rst) begin
      PCWrite    = 1'b0;
      FetchWrite = 1'b0;
      MakeBubble = 1'b1;
      IF_Flush   = 1'b0;
      ex_hold    = 1'b0;
      mem_bubble = 1'b0;
      wb_bubble  = 1'b0;
      mem_hold   = 1'b0;
      mc_go      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mc_go_pend  <= 1'b0;
      mc_done_lat <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mc_go_pend  <= mc_go_pend_nxt;
      mc_done_lat <= mc_done_lat_nxt;
      if (set_err) err_q <= 1'b1;
      if (!PCWrite && stall_q != '1) stall_q <= stall_q + CNT_ONE;
      if (IF_Flush && flush_q != '1) flush_q <= flush_q + CNT_ONE;
    end
  end

  // Registered status reads as zero while reset is held.
  assign mem_error    = rst ? 1'b0 : err_q;
  assign stall_cycles = rst ? '0 : stall_q;
  assign flush_count  = rst ? '0 : flush_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_is_branch, PCSrc;
  logic       id_ex_MemRead, id_ex_RegWrite, mc_start, mc_done, dmem_req, dmem_ready;

  logic        PCWrite, FetchWrite, MakeBubble, IF_Flush, ex_hold, mem_bubble;
  logic        wb_bubble, mem_hold, mc_go, mem_error;
  logic [31:0] stall_cycles, flush_count;

  logic        s_PCWrite, s_FetchWrite, s_MakeBubble, s_IF_Flush, s_ex_hold, s_mem_bubble;
  logic        s_wb_bubble, s_mem_hold, s_mc_go, s_mem_error;
  logic [3:0]  s_stall_cycles, s_flush_count;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_branch(id_is_branch),
    .PCSrc(PCSrc), .id_ex_MemRead(id_ex_MemRead), .id_ex_RegWrite(id_ex_RegWrite),
    .id_ex_rd(id_ex_rd), .mc_start(mc_start), .mc_done(mc_done), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .PCWrite(PCWrite), .FetchWrite(FetchWrite),
    .MakeBubble(MakeBubble), .IF_Flush(IF_Flush), .ex_hold(ex_hold),
    .mem_bubble(mem_bubble), .wb_bubble(wb_bubble), .mem_hold(mem_hold), .mc_go(mc_go),
    .mem_error(mem_error), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_controller #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_s (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_branch(id_is_branch),
    .PCSrc(PCSrc), .id_ex_MemRead(id_ex_MemRead), .id_ex_RegWrite(id_ex_RegWrite),
    .id_ex_rd(id_ex_rd), .mc_start(mc_start), .mc_done(mc_done), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .PCWrite(s_PCWrite), .FetchWrite(s_FetchWrite),
    .MakeBubble(s_MakeBubble), .IF_Flush(s_IF_Flush), .ex_hold(s_ex_hold),
    .mem_bubble(s_mem_bubble), .wb_bubble(s_wb_bubble), .mem_hold(s_mem_hold),
    .mc_go(s_mc_go), .mem_error(s_mem_error), .stall_cycles(s_stall_cycles),
    .flush_count(s_flush_count)
  );

  // Control vector: {PCWrite,FetchWrite,MakeBubble,IF_Flush,ex_hold,
  //                  mem_bubble,wb_bubble,mem_hold,mc_go,mem_error}
  localparam logic [9:0] C_RUN = 10'b1100000000;
  localparam logic [9:0] C_STL = 10'b0010000000;
  localparam logic [9:0] C_FLS = 10'b1101000000;
  localparam logic [9:0] C_MCS = 10'b0000110010;
  localparam logic [9:0] C_MCW = 10'b0000110000;
  localparam logic [9:0] C_MEM = 10'b0000101100;
  localparam logic [9:0] C_OVL = 10'b0000111100;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_stall = 0;
  logic [31:0] model_flush = 0;
  logic [9:0]  dut_ctrl;

  assign dut_ctrl = {PCWrite, FetchWrite, MakeBubble, IF_Flush, ex_hold,
                     mem_bubble, wb_bubble, mem_hold, mc_go, mem_error};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_is_branch = 0; PCSrc = 0; id_ex_MemRead = 0; id_ex_RegWrite = 0;
    mc_start = 0; mc_done = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // One clock cycle: queue the expectation for the current inputs, compare at
  // the falling edge, then step past the next rising edge.
  task automatic cyc_s(input logic [9:0] ctrl, input bit in_rst, input bit chk_s,
                       input logic s_err, input logic s_hold);
    exp_t e, got;
    e.ctrl  = ctrl;
    e.stall = in_rst ? 32'd0 : model_stall;
    e.flush = in_rst ? 32'd0 : model_flush;
    sb.push_back(e);
    if (in_rst) begin
      model_stall = 0;
      model_flush = 0;
    end else begin
      if (!ctrl[9]) model_stall++;
      if (ctrl[6]) model_flush++;
    end
    @(negedge clk);
    got = sb.pop_front();
    chk("ctrl", {22'd0, dut_ctrl}, {22'd0, got.ctrl});
    chk("stall_cycles", stall_cycles, got.stall);
    chk("flush_count", flush_count, got.flush);
    if (chk_s) begin
      chk("s_mem_error", {31'd0, s_mem_error}, {31'd0, s_err});
      chk("s_mem_hold", {31'd0, s_mem_hold}, {31'd0, s_hold});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [9:0] ctrl, input bit in_rst);
    cyc_s(ctrl, in_rst, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1;
    cyc(C_STL, 1);
    cyc(C_STL, 1);
    rst = 0;
    cyc(C_RUN, 0);

    // load-use stall, then rd = 0 gives none
    id_ex_MemRead = 1; id_ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    cyc(C_STL, 0);
    clr();
    cyc(C_RUN, 0);
    chk("stall_after_load_use", stall_cycles, 32'd1);
    id_ex_MemRead = 1; id_ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    cyc(C_RUN, 0);

    // branch after load: two stalls, PCSrc ignored during BR_STALL2
    clr();
    id_ex_MemRead = 1; id_ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    id_is_branch = 1; PCSrc = 1;
    cyc(C_STL, 0);
    clr(); PCSrc = 1;
    cyc(C_STL, 0);
    clr();
    cyc(C_RUN, 0);

    // branch hazard on ALU result
    id_is_branch = 1; id_ex_RegWrite = 1; id_ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    cyc(C_STL, 0);
    clr();
    cyc(C_RUN, 0);

    // taken branch
    PCSrc = 1;
    cyc(C_FLS, 0);
    clr();
    cyc(C_RUN, 0);

    // multi-cycle op: go once, 7 stall cycles
    mc_start = 1;
    cyc(C_MCS, 0);
    repeat (6) cyc(C_MCW, 0);
    mc_done = 1;
    cyc(C_RUN, 0);
    clr();
    cyc(C_RUN, 0);

    // memory wait for 3 cycles
    dmem_req = 1;
    repeat (3) cyc_s(C_MEM, 0, 1, 1'b0, 1'b1);
    dmem_ready = 1;
    cyc_s(C_RUN, 0, 1, 1'b0, 1'b0);
    clr();
    cyc(C_RUN, 0);

    // memory stall overlapping MC_WAIT, early mc_done latched
    mc_start = 1;
    cyc(C_MCS, 0);
    cyc(C_MCW, 0);
    dmem_req = 1; mc_done = 1;
    cyc(C_OVL, 0);
    mc_done = 0;
    cyc(C_OVL, 0);
    dmem_ready = 1;
    cyc(C_RUN, 0);
    clr();
    cyc(C_RUN, 0);

    // timeout on the MEM_TIMEOUT = 4 instance; default instance keeps waiting
    dmem_req = 1;
    repeat (4) cyc_s(C_MEM, 0, 1, 1'b0, 1'b1);
    cyc_s(C_MEM, 0, 1, 1'b0, 1'b0);
    cyc_s(C_MEM, 0, 1, 1'b1, 1'b1);
    dmem_ready = 1;
    cyc_s(C_RUN, 0, 1, 1'b1, 1'b0);
    clr();
    cyc_s(C_RUN, 0, 1, 1'b1, 1'b0);

    // drive enough flushes to saturate the 4-bit counters
    PCSrc = 1;
    repeat (16) cyc(C_FLS, 0);
    clr();
    cyc(C_RUN, 0);
    chk("s_flush_sat", {28'd0, s_flush_count}, 32'd15);
    chk("s_stall_sat", {28'd0, s_stall_cycles}, 32'd15);

    // reset in the middle of MC_WAIT, late mc_done ignored
    mc_start = 1;
    cyc(C_MCS, 0);
    cyc(C_MCW, 0);
    rst = 1;
    cyc_s(C_STL, 1, 1, 1'b0, 1'b0);
    rst = 0; mc_start = 0; mc_done = 1;
    cyc_s(C_RUN, 0, 1, 1'b0, 1'b0);
    clr();
    cyc(C_RUN, 0);
    chk("s_stall_after_rst", {28'd0, s_stall_cycles}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central stall/flush sequencer for the 5-stage pipeline. It takes hazard and status inputs from decode (`decode_stage`), execute (multi-cycle unit) and memory (data-memory handshake). It produces every pipeline-register enable, bubble and flush, and replaces the purely combinational load-use logic. A small FSM covers multi-cycle waits, a branch-after-load double stall and data-memory wait states. It also maintains saturating performance counters.

## Interface
Parameters:
- `CNT_W`, 32: width of each performance counter.
- `MEM_TIMEOUT`, 255: maximum number of `MEM_WAIT` cycles before abort.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction actually reads that source.
- `id_is_branch` in 1: the ID instruction is B_TYPE.
- `PCSrc` in 1: branch taken, resolved in ID.
- `id_ex_MemRead` in 1: the EX instruction is a load.
- `id_ex_RegWrite` in 1: the EX instruction writes a register.
- `id_ex_rd` in 5: destination register of the EX instruction.
- `mc_start` in 1: the EX instruction is a multi-cycle op (level).
- `mc_done` in 1: one-cycle pulse from the multi-cycle unit.
- `dmem_req` in 1: the MEM instruction accesses data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `PCWrite` out 1: PC register enable.
- `FetchWrite` out 1: IF/ID register enable.
- `MakeBubble` out 1: zero the control word going into ID/EX.
- `IF_Flush` out 1: zero IF/ID.
- `ex_hold` out 1: hold ID/EX.
- `mem_bubble` out 1: insert a bubble into EX/MEM.
- `wb_bubble` out 1: insert a bubble into MEM/WB.
- `mem_hold` out 1: hold EX/MEM.
- `mc_go` out 1: start pulse to the multi-cycle unit.
- `mem_error` out 1: sticky flag, set on a memory timeout.
- `stall_cycles` out CNT_W: count of stalled cycles.
- `flush_count` out CNT_W: count of IF flushes.

## Operation
- FSM states are RUN, MC_WAIT, MEM_WAIT and BR_STALL2. The auxiliary registers are `wait_cnt` [7:0] and `mc_go_pend`.
- **Priority in RUN, highest first:**
  1. Memory wait: `dmem_req && !dmem_ready`.
  2. Multi-cycle start: `mc_start`.
  3. Load-use hazard.
  4. Branch hazard.
  5. Taken branch.
- **RUN with no event:**
  - `PCWrite` = `FetchWrite` = 1.
  - All other control outputs are 0.
- **Memory wait:**
  - Same cycle: `PCWrite` = `FetchWrite` = 0, `ex_hold` = 1, `mem_hold` = 1, `wb_bubble` = 1.
  - Next state is MEM_WAIT; `wait_cnt` is set to 1.
- **MEM_WAIT:**
  - Holds the same outputs as the memory-wait cycle.
  - `wait_cnt` increments each cycle.
  - On `dmem_ready`, go to RUN next cycle. `wb_bubble` = 0 in the ready cycle, so the data is captured.
  - If `wait_cnt == MEM_TIMEOUT` and not `dmem_ready`: set `mem_error` (sticky until `rst`), release all holds, go to RUN.
- **Multi-cycle start:**
  - Same cycle: `PCWrite` = `FetchWrite` = 0, `ex_hold` = 1, `mem_bubble` = 1, `mc_go` = 1.
  - Next state is MC_WAIT.
- **MC_WAIT:**
  - Same stall outputs as the start cycle, except `mc_go` = 0.
  - On `mc_done`: `ex_hold` = 0, `mem_bubble` = 0, `PCWrite` = `FetchWrite` = 1, next state RUN.
  - If a memory wait begins while in MC_WAIT, the memory holds are OR-ed in. The state stays MC_WAIT.
  - `mc_done` arriving during such an overlap is latched and honoured once `dmem_ready` arrives.
- **Load-use hazard:**
  - Condition: `id_ex_MemRead && id_ex_rd != 0 && ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd))`.
  - If `id_is_branch` is also set: `PCWrite` = `FetchWrite` = 0, `MakeBubble` = 1, next state BR_STALL2. This is the second bubble needed because branches resolve in ID.
  - Otherwise: one cycle of `PCWrite` = `FetchWrite` = 0 and `MakeBubble` = 1; the state stays RUN.
- **Branch hazard:**
  - Condition: `id_is_branch && id_ex_RegWrite && !id_ex_MemRead`, with `id_ex_rd` nonzero and matching a used source.
  - Response: one-cycle stall, same outputs as the single load-use stall.
- **BR_STALL2:** one further cycle with `PCWrite` = `FetchWrite` = 0 and `MakeBubble` = 1, then RUN.
- **Taken branch:**
  - Condition: `PCSrc` in RUN with no higher-priority event.
  - Response: `IF_Flush` = 1 and `PCWrite` = 1.
  - `PCSrc` is ignored whenever any stall is active.
- **`stall_cycles`:** +1 in every cycle where `PCWrite` = 0.
- **`flush_count`:** +1 in every cycle with `IF_Flush` = 1.
- **Counter width:** both counters saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from the registered state and the current inputs, with zero-cycle latency. The state, `wait_cnt`, `mem_error` and the counters are registered.
- **While `rst` = 1:**
  - `PCWrite` = `FetchWrite` = 0 and `MakeBubble` = 1.
  - All other outputs are 0.
  - On the next edge: state = RUN, counters = 0, `mem_error` = 0, `wait_cnt` = 0, latched `mc_done` cleared.
- Reset mid-MC_WAIT or mid-MEM_WAIT aborts the operation. The cycle after reset deasserts is a plain RUN cycle.
- `mc_go` is high for exactly one cycle per multi-cycle op. It never re-fires while in MC_WAIT.
- Reset-cycle stalls are not counted.

## Test plan
- **Load-use stall:**
  - Stimulus: `id_ex_MemRead` = 1, `id_ex_rd` = 5, `id_rs1` = 5, `id_uses_rs1` = 1.
  - Response: exactly 1 cycle with `PCWrite` = 0, `MakeBubble` = 1; `stall_cycles` = 1.
  - Repeat with `id_ex_rd` = 0: no stall.
- **Branch after load:**
  - Stimulus: same load-use condition with `id_is_branch` = 1.
  - Response: 2 consecutive stall cycles (RUN→BR_STALL2→RUN); `PCSrc` = 1 during the stall gives `IF_Flush` = 0.
- **Multi-cycle op:**
  - Stimulus: `mc_start` held; `mc_done` pulsed 6 cycles later.
  - Response: `mc_go` high for 1 cycle; `ex_hold` high for 7 cycles; `stall_cycles` = 7.
- **Memory wait:**
  - Stimulus: `dmem_req` = 1 with `dmem_ready` low for 3 cycles.
  - Response: `mem_hold` and `wb_bubble` high for 3 cycles; RUN resumes the cycle after ready.
  - Variant: `MEM_TIMEOUT` = 4 with ready never asserted. Response: `mem_error` = 1 after 4 MEM_WAIT cycles, and it stays set.
- **Taken branch:**
  - Stimulus: `PCSrc` = 1 in RUN.
  - Response: `IF_Flush` = 1 and `PCWrite` = 1 in the same cycle; `flush_count` increments by 1.
  - Saturation check: force the counters to all-ones via `CNT_W` = 4. Response: they hold at 15.
- **Reset mid-MC_WAIT:**
  - Stimulus: assert `rst` for 1 cycle during MC_WAIT.
  - Response: outputs go to reset values; next cycle `PCWrite` = 1, counters = 0, and a late `mc_done` is ignored.
